// File: rtl/axi_lite_sram_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_pkg
//  Description : Shared definitions for the AXI4-Lite SRAM responder:
//                data/address widths, AXI response codes and the
//                read/write FSM state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_lite_pkg;

    localparam int DATA_W = 64;
    localparam int STRB_W = DATA_W / 8;
    localparam int ADDR_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Read FSM encoding
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_RESP = 2'd2;

    // Write FSM encoding
    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;

endpackage
`default_nettype wire

// File: rtl/axi_lite_sram_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_sram_slave_if
//  Description : AXI4-Lite bus bundle (AR/R read channels, AW/W/B write
//                channels). The master modport drives addresses, data and
//                response-ready; the slave modport drives ready/valid/data
//                back.
//  Ports       : araddr/arvalid/arready, rdata/rresp/rvalid/rready,
//                awaddr/awvalid/awready, wdata/wstrb/wvalid/wready,
//                bresp/bvalid/bready
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_lite_sram_slave_if;
    import axi_lite_pkg::*;

    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output araddr, arvalid, rready,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );

endinterface
`default_nettype wire

// File: rtl/axi_lite_sram_slave_sram_1r1w_strb.sv
`default_nettype none
// ============================================================================
//  Module      : sram_1r1w_strb
//  Description : DEPTH x 64-bit RAM, one synchronous read port and one
//                byte-strobed synchronous write port. Storage is not reset;
//                only the read-data register clears on rst. A read and a
//                write to the same word on the same edge return old data.
//  Ports       : clk, rst
//                rd_en_i, rd_addr_i -> rd_data_o (valid after the edge)
//                wr_en_i, wr_addr_i, wr_data_i, wr_strb_i
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_1r1w_strb
    import axi_lite_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              rd_en_i,
    input  wire logic [IDX_W-1:0]  rd_addr_i,
    output logic      [DATA_W-1:0] rd_data_o,
    input  wire logic              wr_en_i,
    input  wire logic [IDX_W-1:0]  wr_addr_i,
    input  wire logic [DATA_W-1:0] wr_data_i,
    input  wire logic [STRB_W-1:0] wr_strb_i
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb_i[b]) begin
                    mem_q[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
                end
            end
        end
    end

    assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/axi_lite_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_sram_slave
//  Description : AXI4-Lite responder with 64-bit single-beat read and write
//                channels backed by an on-chip word RAM. Read data appears
//                RD_LAT+1 cycles after AR acceptance (RD_LAT=0 -> the cycle
//                after). AW and W are accepted independently; the write
//                commits on the edge where both are held.
//  Params      : DEPTH (words, power of 2), BASE (byte address of word 0),
//                RD_LAT (0..15)
//  Ports       : clk, rst (sync, active-high), bus (axi_lite_sram_slave_if.slave)
//  Macro       : AXI_SLV_ERR_EN - out-of-range accesses answer SLVERR
//                (reads return 0, writes are dropped); otherwise the index
//                wraps modulo DEPTH and every response is OKAY.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_sram_slave
    import axi_lite_pkg::*;
#(
    parameter int          DEPTH  = 1024,
    parameter logic [63:0] BASE   = 64'h8000_0000,
    parameter int          RD_LAT = 1
) (
    input wire logic              clk,
    input wire logic              rst,
    axi_lite_sram_slave_if.slave  bus
);

    localparam int               IDX_W   = $clog2(DEPTH);
    localparam logic [31:0]      BASE_LO = BASE[31:0];
    localparam logic [3:0]       LAT     = 4'(RD_LAT);

    // Word index; addr[2:0] drop out with the shift.
    function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE_LO) >> 3);
    endfunction

`ifdef AXI_SLV_ERR_EN
    function automatic logic addr_oor(input logic [ADDR_W-1:0] a);
        return (a < BASE_LO) || (((a - BASE_LO) >> 3) >= 32'(DEPTH));
    endfunction
`endif

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    logic [1:0]        r_state_q, r_state_d;
    logic [3:0]        r_cnt_q,   r_cnt_d;
    logic [ADDR_W-1:0] r_addr_q,  r_addr_d;
    logic [1:0]        rresp_q,   rresp_d;
    logic              rd_err_q,  rd_err_d;

    logic              w_ar_hs;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_rd_err;
    logic              w_ram_rd_en;
    logic [DATA_W-1:0] w_ram_rdata;

    assign w_ar_hs = bus.arvalid & bus.arready;
    // With RD_LAT=0 the RAM is read on the accept edge, straight off the bus.
    assign w_rd_addr = (r_state_q == R_IDLE) ? bus.araddr : r_addr_q;

`ifdef AXI_SLV_ERR_EN
    assign w_rd_err = addr_oor(w_rd_addr);
`else
    assign w_rd_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_cnt_q   <= '0;
            r_addr_q  <= '0;
            rresp_q   <= RESP_OKAY;
            rd_err_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            r_addr_q  <= r_addr_d;
            rresp_q   <= rresp_d;
            rd_err_q  <= rd_err_d;
        end
    end

    always_comb begin
        r_state_d   = r_state_q;
        r_cnt_d     = r_cnt_q;
        r_addr_d    = r_addr_q;
        rresp_d     = rresp_q;
        rd_err_d    = rd_err_q;
        w_ram_rd_en = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (w_ar_hs) begin
                    r_addr_d = bus.araddr;
                    r_cnt_d  = LAT;
                    if (LAT == 4'd0) begin
                        w_ram_rd_en = 1'b1;
                        rresp_d     = w_rd_err ? RESP_SLVERR : RESP_OKAY;
                        rd_err_d    = w_rd_err;
                        r_state_d   = R_RESP;
                    end else begin
                        r_state_d   = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                r_cnt_d = r_cnt_q - 4'd1;
                if (r_cnt_q == 4'd1) begin
                    w_ram_rd_en = 1'b1;
                    rresp_d     = w_rd_err ? RESP_SLVERR : RESP_OKAY;
                    rd_err_d    = w_rd_err;
                    r_state_d   = R_RESP;
                end
            end
            R_RESP: begin
                if (bus.rready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        bus.arready = (r_state_q == R_IDLE);
        bus.rvalid  = (r_state_q == R_RESP);
        bus.rresp   = rresp_q;
        bus.rdata   = rd_err_q ? '0 : w_ram_rdata;
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    logic [0:0]        w_state_q, w_state_d;
    logic              aw_held_q, aw_held_d;
    logic              wd_held_q, wd_held_d;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
    logic [DATA_W-1:0] wd_data_q, wd_data_d;
    logic [STRB_W-1:0] wd_strb_q, wd_strb_d;
    logic [1:0]        bresp_q,   bresp_d;

    logic              w_aw_hs, w_w_hs, w_commit, w_wr_err, w_ram_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic [STRB_W-1:0] w_wr_strb;

    assign w_aw_hs = bus.awvalid & bus.awready;
    assign w_w_hs  = bus.wvalid  & bus.wready;

    // Use the bus value when the handshake is happening this cycle so a
    // same-cycle AW+W (or completion of the second half) commits at once.
    assign w_wr_addr = aw_held_q ? aw_addr_q : bus.awaddr;
    assign w_wr_data = wd_held_q ? wd_data_q : bus.wdata;
    assign w_wr_strb = wd_held_q ? wd_strb_q : bus.wstrb;
    assign w_commit  = (w_state_q == W_IDLE)
                     & (aw_held_q | w_aw_hs)
                     & (wd_held_q | w_w_hs);

`ifdef AXI_SLV_ERR_EN
    assign w_wr_err = addr_oor(w_wr_addr);
`else
    assign w_wr_err = 1'b0;
`endif

    // Reset on the same edge must suppress the write.
    assign w_ram_wr_en = w_commit & ~w_wr_err & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            wd_held_q <= 1'b0;
            aw_addr_q <= '0;
            wd_data_q <= '0;
            wd_strb_q <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            wd_held_q <= wd_held_d;
            aw_addr_q <= aw_addr_d;
            wd_data_q <= wd_data_d;
            wd_strb_q <= wd_strb_d;
            bresp_q   <= bresp_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        wd_held_d = wd_held_q;
        aw_addr_d = aw_addr_q;
        wd_data_d = wd_data_q;
        wd_strb_d = wd_strb_q;
        bresp_d   = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (w_aw_hs) begin
                    aw_held_d = 1'b1;
                    aw_addr_d = bus.awaddr;
                end
                if (w_w_hs) begin
                    wd_held_d = 1'b1;
                    wd_data_d = bus.wdata;
                    wd_strb_d = bus.wstrb;
                end
                if (w_commit) begin
                    bresp_d   = w_wr_err ? RESP_SLVERR : RESP_OKAY;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bus.bready) begin
                    aw_held_d = 1'b0;
                    wd_held_d = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        bus.awready = (w_state_q == W_IDLE) & ~aw_held_q;
        bus.wready  = (w_state_q == W_IDLE) & ~wd_held_q;
        bus.bvalid  = (w_state_q == W_RESP);
        bus.bresp   = bresp_q;
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    sram_1r1w_strb #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .rd_en_i   (w_ram_rd_en),
        .rd_addr_i (addr_index(w_rd_addr)),
        .rd_data_o (w_ram_rdata),
        .wr_en_i   (w_ram_wr_en),
        .wr_addr_i (addr_index(w_wr_addr)),
        .wr_data_i (w_wr_data),
        .wr_strb_i (w_wr_strb)
    );

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_lite_sram_slave
//  Description : Self-checking bench for axi_lite_sram_slave. Expected read
//                and write responses are queued when a transaction is
//                issued and compared when the DUT answers; a word-level
//                reference memory supplies the expected read data.
//  Macro       : AXI_SLV_ERR_EN selects the out-of-range expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_sram_slave;

    localparam int          DEPTH  = 1024;
    localparam int          RD_LAT = 1;
    localparam logic [31:0] BASE_A = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_lite_sram_slave_if bus ();

    axi_lite_sram_slave #(
        .DEPTH  (DEPTH),
        .BASE   (64'h8000_0000),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [63:0] model [int];
    logic [65:0] rq [$];
    logic [1:0]  bq [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int m_idx(input logic [31:0] a);
        logic [31:0] o;
        o = (a - BASE_A) >> 3;
        return int'(o % 32'(DEPTH));
    endfunction

    function automatic logic m_oor(input logic [31:0] a);
`ifdef AXI_SLV_ERR_EN
        return (a < BASE_A) || (((a - BASE_A) >> 3) >= 32'(DEPTH));
`else
        return 1'b0 & a[0];
`endif
    endfunction

    function automatic logic [63:0] m_read(input logic [31:0] a);
        if (m_oor(a)) return 64'h0;
        if (model.exists(m_idx(a))) return model[m_idx(a)];
        return 64'h0;
    endfunction

    // w_lead > 0: W is presented alone and AW follows w_lead cycles later.
    task automatic do_write(input logic [31:0] a, input logic [63:0] d,
                            input logic [7:0] s, input int w_lead, input int b_hold);
        logic [63:0] tmp;
        bit          aw_done, w_done, awh, wh;
        int          cyc;
        bq.push_back(m_oor(a) ? 2'b10 : 2'b00);
        if (!m_oor(a)) begin
            tmp = model.exists(m_idx(a)) ? model[m_idx(a)] : 64'h0;
            for (int b = 0; b < 8; b++)
                if (s[b]) tmp[8*b +: 8] = d[8*b +: 8];
            model[m_idx(a)] = tmp;
        end
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s; bus.bready = 1'b0;
        aw_done = 0; w_done = 0;
        if (w_lead > 0) begin
            bus.wvalid = 1'b1;
            cyc = 0;
            while (!w_done && cyc < 20) begin
                @(negedge clk); wh = bus.wvalid & bus.wready;
                @(posedge clk); #1; cyc++;
                if (wh) begin w_done = 1; bus.wvalid = 1'b0; end
            end
            chk("w_only_accept", 64'(w_done), 64'd1);
            chk("wready_drop", 64'(bus.wready), 64'd0);
            repeat (w_lead - 1) begin @(posedge clk); #1; end
            chk("w_only_no_b", 64'(bus.bvalid), 64'd0);
            chk("wready_held_low", 64'(bus.wready), 64'd0);
        end
        bus.awvalid = 1'b1;
        bus.wvalid  = !w_done;
        cyc = 0;
        while (!(aw_done && w_done) && cyc < 20) begin
            @(negedge clk); awh = bus.awvalid & bus.awready; wh = bus.wvalid & bus.wready;
            @(posedge clk); #1; cyc++;
            if (awh) begin aw_done = 1; bus.awvalid = 1'b0; end
            if (wh)  begin w_done  = 1; bus.wvalid  = 1'b0; end
        end
        chk("wr_accept", 64'(aw_done && w_done), 64'd1);
        chk("b_after_commit", 64'(bus.bvalid), 64'd1);
        repeat (b_hold) begin
            @(posedge clk); #1;
            chk("b_hold_valid", 64'(bus.bvalid), 64'd1);
            chk("b_hold_awready", 64'(bus.awready), 64'd0);
        end
        bus.bready = 1'b1;
        @(negedge clk);
        chk("bvalid_at_hs", 64'(bus.bvalid), 64'd1);
        chk("bresp", 64'(bus.bresp), 64'(bq.pop_front()));
        @(posedge clk); #1;
        bus.bready = 1'b0;
        chk("b_single_pulse", 64'(bus.bvalid), 64'd0);
        chk("awready_back", 64'(bus.awready), 64'd1);
        chk("wready_back", 64'(bus.wready), 64'd1);
    endtask

    task automatic do_read(input logic [31:0] a, input int r_hold);
        logic [65:0] exp;
        bit          arh, got_ar;
        int          cyc;
        rq.push_back({(m_oor(a) ? 2'b10 : 2'b00), m_read(a)});
        bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b0;
        got_ar = 0; cyc = 0;
        while (!got_ar && cyc < 20) begin
            @(negedge clk); arh = bus.arvalid & bus.arready;
            @(posedge clk); #1; cyc++;
            if (arh) begin got_ar = 1; bus.arvalid = 1'b0; end
        end
        chk("ar_accept", 64'(got_ar), 64'd1);
        cyc = 1;
        while (!bus.rvalid && cyc < 40) begin
            chk("arready_busy", 64'(bus.arready), 64'd0);
            @(posedge clk); #1; cyc++;
        end
        chk("r_latency", 64'(cyc), 64'(RD_LAT + 1));
        exp = rq[0];
        repeat (r_hold) begin
            @(posedge clk); #1;
            chk("r_hold_valid", 64'(bus.rvalid), 64'd1);
            chk("r_hold_data", bus.rdata, exp[63:0]);
            chk("r_hold_arready", 64'(bus.arready), 64'd0);
        end
        bus.rready = 1'b1;
        @(negedge clk);
        exp = rq.pop_front();
        chk("rdata", bus.rdata, exp[63:0]);
        chk("rresp", 64'(bus.rresp), 64'(exp[65:64]));
        @(posedge clk); #1;
        bus.rready = 1'b0;
        chk("r_done", 64'(bus.rvalid), 64'd0);
        chk("arready_back", 64'(bus.arready), 64'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0;
        bus.wstrb  = '0; bus.wvalid  = 1'b0; bus.bready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_arready", 64'(bus.arready), 64'd1);
        chk("rst_awready", 64'(bus.awready), 64'd1);
        chk("rst_wready",  64'(bus.wready),  64'd1);
        chk("rst_rvalid",  64'(bus.rvalid),  64'd0);
        chk("rst_bvalid",  64'(bus.bvalid),  64'd0);
        chk("rst_rdata",   bus.rdata,        64'd0);
        chk("rst_rresp",   64'(bus.rresp),   64'd0);
        chk("rst_bresp",   64'(bus.bresp),   64'd0);

        // Preload words 0..7 and the top word
        do_write(BASE_A, 64'h0000_0013_0000_0093, 8'hFF, 0, 0);
        for (int i = 1; i < 8; i++)
            do_write(BASE_A + 32'(8*i), {$urandom, $urandom}, 8'hFF, 0, 0);
        do_write(BASE_A + 32'(8*(DEPTH-1)), 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, 0, 0);

        // Basic read of the preloaded word
        do_read(BASE_A, 0);

        // Partial-strobe write keeps the upper half
        do_write(BASE_A + 32'h8, 64'h1122_3344_5566_7788, 8'h0F, 0, 0);
        do_read(BASE_A + 32'h8, 0);

        // W well ahead of AW, slow bready
        do_write(BASE_A + 32'h10, 64'hCAFE_F00D_1234_5678, 8'hFF, 3, 2);
        do_read(BASE_A + 32'h10, 5);

        // Low address bits ignored; top word
        do_read(BASE_A + 32'h8 + 32'h5, 1);
        do_read(BASE_A + 32'(8*(DEPTH-1)), 0);

        // Randomised traffic inside the preloaded window
        for (int i = 0; i < 10; i++) begin
            logic [31:0] a;
            a = BASE_A + 32'(8 * $urandom_range(0, 7)) + 32'($urandom_range(0, 7));
            do_write(a, {$urandom, $urandom}, 8'($urandom_range(0, 255)),
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            do_read(a, int'($urandom_range(0, 3)));
        end

        // Reset while read is waiting and AW is latched
        bus.araddr = BASE_A; bus.arvalid = 1'b1;
        bus.awaddr = BASE_A + 32'h18; bus.awvalid = 1'b1;
        @(posedge clk); #1;
        bus.arvalid = 1'b0; bus.awvalid = 1'b0;
        chk("pre_rst_arready", 64'(bus.arready), 64'd0);
        chk("pre_rst_awready", 64'(bus.awready), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_arready", 64'(bus.arready), 64'd1);
        chk("mid_rst_awready", 64'(bus.awready), 64'd1);
        chk("mid_rst_wready",  64'(bus.wready),  64'd1);
        chk("mid_rst_rvalid",  64'(bus.rvalid),  64'd0);
        chk("mid_rst_bvalid",  64'(bus.bvalid),  64'd0);
        chk("mid_rst_rdata",   bus.rdata,        64'd0);
        @(posedge clk); #1;
        chk("post_rst_rvalid", 64'(bus.rvalid), 64'd0);
        do_read(BASE_A + 32'h18, 0);
        do_read(BASE_A, 0);

        // One word past the end: SLVERR with the feature, wrap to word 0 without
        do_read(BASE_A + 32'(8*DEPTH), 0);
        do_write(BASE_A + 32'(8*DEPTH), 64'h5A5A_5A5A_A5A5_A5A5, 8'hFF, 0, 1);
        do_read(BASE_A, 0);
`ifdef AXI_SLV_ERR_EN
        do_read(BASE_A - 32'h8, 0);
        do_write(BASE_A - 32'h8, 64'h0123_4567_89AB_CDEF, 8'hFF, 1, 0);
        do_read(BASE_A + 32'(8*(DEPTH-1)), 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
